// File: rtl/op_sequencer.sv
// op_sequencer: owns the instruction register, per-instruction step counter,
// CB-prefix state, conditional early termination, HALT and interrupt dispatch.
// Optional feature macro: OP_SEQUENCER_HALT_BUG_EN (HALT bug, drives pc_hold).
module op_sequencer #(
    parameter int         STEP_W      = 3,
    parameter int         N_IRQ       = 5,
    parameter logic [7:0] PREFIX_OP   = 8'hCB,
    parameter logic [7:0] DISPATCH_OP = 8'hD3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic              is_cond,
    input  logic [1:0]        cond,
    input  logic [3:0]        flags,
    input  logic [7:0]        d_in,
    input  logic              halt_req,
    input  logic              ei,
    input  logic              di,
    input  logic              reti,
    input  logic [N_IRQ-1:0]  irq_req,
    output logic [7:0]        ir,
    output logic              prefix,
    output logic [STEP_W-1:0] step,
    output logic              fetch,
    output logic [N_IRQ-1:0]  irq_ack,
    output logic [7:0]        vector,
    output logic              ime,
    output logic              halted,
    output logic              fault,
    output logic              pc_hold
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};

    // Condition code truth: 00 NZ, 01 Z, 10 NC, 11 C; flags are {Z,N,H,C}.
    function automatic logic cond_true(input logic [1:0] c, input logic [3:0] f);
        logic r;
        case (c)
            2'b00:   r = ~f[3];
            2'b01:   r = f[3];
            2'b10:   r = ~f[0];
            2'b11:   r = f[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    state_t            state_r, state_n;
    logic [7:0]        ir_r, ir_n;
    logic              prefix_r, prefix_n;
    logic [STEP_W-1:0] step_r, step_n;
    logic [N_IRQ-1:0]  irq_ack_r, irq_ack_n;
    logic [7:0]        vector_r, vector_n;
    logic              ime_r, ime_n;
    logic              ei_pend_r, ei_pend_n;
    logic              halted_r, halted_n;
    logic              fault_r, fault_n;
`ifdef OP_SEQUENCER_HALT_BUG_EN
    logic              pc_hold_r, pc_hold_n;
`endif

    logic              end_s;
    logic              irq_any_s;
    logic [N_IRQ-1:0]  irq_onehot_s;
    logic [7:0]        irq_vec_s;
    logic              ime_upd_s;
    logic              ei_pend_upd_s;
    logic              unused_flags_s;

    // N and H flags are not used by any condition code.
    assign unused_flags_s = ^flags[2:1];

    // End detection, lowest-index interrupt select and end-of-instruction IME update.
    always_comb begin
        end_s        = done | (is_cond & ~cond_true(cond, flags));
        irq_any_s    = |irq_req;
        irq_onehot_s = '0;
        irq_vec_s    = 8'h40;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (irq_req[i]) begin
                irq_onehot_s    = '0;
                irq_onehot_s[i] = 1'b1;
                irq_vec_s       = 8'h40 + 8'(i * 8);
            end else begin
                irq_onehot_s = irq_onehot_s;
            end
        end
        // DI wins over everything; a pending EI or RETI raises IME; EI re-arms the pending flag.
        ime_upd_s     = di ? 1'b0 : ((reti | ei_pend_r) ? 1'b1 : ime_r);
        ei_pend_upd_s = di ? 1'b0 : ei;
    end

    // Next-state and next-register logic for RUN / HALT / FAULT.
    always_comb begin
        state_n   = state_r;
        ir_n      = ir_r;
        prefix_n  = prefix_r;
        step_n    = step_r;
        irq_ack_n = '0;
        vector_n  = vector_r;
        ime_n     = ime_r;
        ei_pend_n = ei_pend_r;
        halted_n  = halted_r;
        fault_n   = fault_r;
`ifdef OP_SEQUENCER_HALT_BUG_EN
        pc_hold_n = 1'b0;
`endif
        case (state_r)
            ST_RUN: begin
                if (end_s) begin
                    step_n = '0;
                    if ((ir_r == PREFIX_OP) && !prefix_r) begin
                        // Prefix byte: next opcode comes from the CB table, no interrupt window.
                        ir_n     = d_in;
                        prefix_n = 1'b1;
                    end else begin
                        prefix_n  = 1'b0;
                        ime_n     = ime_upd_s;
                        ei_pend_n = ei_pend_upd_s;
                        if (halt_req) begin
`ifdef OP_SEQUENCER_HALT_BUG_EN
                            if (!ime_r && irq_any_s) begin
                                // HALT bug: no halt, the next opcode byte is fetched twice.
                                ir_n      = d_in;
                                pc_hold_n = 1'b1;
                            end else begin
                                state_n  = ST_HALT;
                                halted_n = 1'b1;
                            end
`else
                            state_n  = ST_HALT;
                            halted_n = 1'b1;
`endif
                        end else if (ime_r && irq_any_s) begin
                            // Interrupt check uses the IME value from before this update.
                            ir_n      = DISPATCH_OP;
                            ime_n     = 1'b0;
                            irq_ack_n = irq_onehot_s;
                            vector_n  = irq_vec_s;
                        end else begin
                            ir_n = d_in;
                        end
                    end
                end else if (step_r == STEP_MAX) begin
                    state_n = ST_FAULT;
                    fault_n = 1'b1;
                end else begin
                    step_n = step_r + STEP_W'(1);
                end
            end
            ST_HALT: begin
                step_n = '0;
                if (irq_any_s) begin
                    state_n  = ST_RUN;
                    halted_n = 1'b0;
                    if (ime_r) begin
                        ir_n      = DISPATCH_OP;
                        ime_n     = 1'b0;
                        irq_ack_n = irq_onehot_s;
                        vector_n  = irq_vec_s;
                    end else begin
                        ir_n = d_in;
                    end
                end else begin
                    state_n = ST_HALT;
                end
            end
            ST_FAULT: begin
                state_n   = ST_FAULT;
                irq_ack_n = irq_ack_r;
            end
            default: begin
                state_n = ST_FAULT;
                fault_n = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            ir_r      <= 8'h00;
            prefix_r  <= 1'b0;
            step_r    <= '0;
            irq_ack_r <= '0;
            vector_r  <= 8'h00;
            ime_r     <= 1'b0;
            ei_pend_r <= 1'b0;
            halted_r  <= 1'b0;
            fault_r   <= 1'b0;
`ifdef OP_SEQUENCER_HALT_BUG_EN
            pc_hold_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_n;
            ir_r      <= ir_n;
            prefix_r  <= prefix_n;
            step_r    <= step_n;
            irq_ack_r <= irq_ack_n;
            vector_r  <= vector_n;
            ime_r     <= ime_n;
            ei_pend_r <= ei_pend_n;
            halted_r  <= halted_n;
            fault_r   <= fault_n;
`ifdef OP_SEQUENCER_HALT_BUG_EN
            pc_hold_r <= pc_hold_n;
`endif
        end
    end

    assign fetch   = (state_r == ST_RUN) & end_s;
    assign ir      = ir_r;
    assign prefix  = prefix_r;
    assign step    = step_r;
    assign irq_ack = irq_ack_r;
    assign vector  = vector_r;
    assign ime     = ime_r;
    assign halted  = halted_r;
    assign fault   = fault_r;
`ifdef OP_SEQUENCER_HALT_BUG_EN
    assign pc_hold = pc_hold_r;
`else
    assign pc_hold = 1'b0;
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer: directed scenarios plus a randomized run against
// a behavioural model. Honours OP_SEQUENCER_HALT_BUG_EN when defined.
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       rst, done, is_cond, halt_req, ei, di, reti;
    logic [1:0] cond;
    logic [3:0] flags;
    logic [7:0] d_in;
    logic [4:0] irq_req;
    logic [7:0] ir, vector;
    logic       prefix, fetch, ime, halted, fault, pc_hold;
    logic [2:0] step;
    logic [4:0] irq_ack;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_ir, m_vec;
    logic [2:0] m_step;
    logic [4:0] m_ack;
    bit         m_prefix, m_ime, m_eip, m_halt, m_fault, m_pch;

    always #5 clk = ~clk;

    op_sequencer #(.STEP_W(3), .N_IRQ(5), .PREFIX_OP(8'hCB), .DISPATCH_OP(8'hD3)) dut (
        .clk(clk), .rst(rst), .done(done), .is_cond(is_cond), .cond(cond), .flags(flags),
        .d_in(d_in), .halt_req(halt_req), .ei(ei), .di(di), .reti(reti), .irq_req(irq_req),
        .ir(ir), .prefix(prefix), .step(step), .fetch(fetch), .irq_ack(irq_ack),
        .vector(vector), .ime(ime), .halted(halted), .fault(fault), .pc_hold(pc_hold)
    );

    task automatic clear_inputs();
        rst = 1'b0; done = 1'b0; is_cond = 1'b0; halt_req = 1'b0; ei = 1'b0; di = 1'b0;
        reti = 1'b0; cond = 2'b00; flags = 4'h0; d_in = 8'h00; irq_req = 5'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ir = 8'h00; m_step = 3'd0; m_prefix = 0; m_ime = 0; m_eip = 0;
        m_halt = 0; m_fault = 0; m_ack = 5'b0; m_vec = 8'h00; m_pch = 0;
    endtask

    // True when the current inputs end the instruction (done or a failed condition).
    function automatic bit m_ends();
        bit sel;
        sel = cond[1] ? flags[0] : flags[3];
        return done || (is_cond && (sel != cond[0]));
    endfunction

    task automatic model_dispatch();
        for (int i = 0; i < 5; i++) begin
            if (irq_req[i]) begin
                m_ack = 5'(1 << i);
                m_vec = 8'(64 + 8 * i);
                break;
            end
        end
        m_ir  = 8'hD3;
        m_ime = 0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit old_ime;
        if (rst) begin model_reset(); return; end
        if (m_fault) return;
        m_ack = 5'b0;
        m_pch = 0;
        if (m_halt) begin
            if (irq_req != 5'b0) begin
                m_halt = 0;
                if (m_ime) model_dispatch();
                else m_ir = d_in;
            end
            return;
        end
        if (!m_ends()) begin
            if (m_step == 3'd7) m_fault = 1;
            else m_step = m_step + 3'd1;
            return;
        end
        m_step = 3'd0;
        if (m_ir == 8'hCB && !m_prefix) begin
            m_ir = d_in;
            m_prefix = 1;
            return;
        end
        m_prefix = 0;
        old_ime  = m_ime;
        if (m_eip) begin m_ime = 1; m_eip = 0; end
        if (ei) m_eip = 1;
        if (reti) m_ime = 1;
        if (di) begin m_ime = 0; m_eip = 0; end
        if (halt_req) begin
`ifdef OP_SEQUENCER_HALT_BUG_EN
            if (!old_ime && irq_req != 5'b0) begin m_ir = d_in; m_pch = 1; end
            else m_halt = 1;
`else
            m_halt = 1;
`endif
        end else if (old_ime && irq_req != 5'b0) begin
            model_dispatch();
        end else begin
            m_ir = d_in;
        end
    endtask

    task automatic test_reset();
        clear_inputs(); rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        checks++; if (ir !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h expected 00", ir); end
        checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
        checks++; if ({prefix, ime, halted, fault, pc_hold} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {prefix, ime, halted, fault, pc_hold}); end
        checks++; if (irq_ack !== 5'b0 || vector !== 8'h00) begin errors++; $display("FAIL reset_irq: got ack %b vec %h expected 00000 00", irq_ack, vector); end
        done = 1'b1; d_in = 8'h3E; #1;
        checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL first_fetch: got %b expected 1", fetch); end
        cyc();
        checks++; if (ir !== 8'h3E || step !== 3'd0 || prefix !== 1'b0 || ime !== 1'b0) begin errors++; $display("FAIL first_op: got ir %h step %0d pfx %b ime %b expected 3e 0 0 0", ir, step, prefix, ime); end
    endtask

    task automatic test_prefix();
        clear_inputs(); reti = 1'b1; done = 1'b1; d_in = 8'hCB; cyc();
        checks++; if (ir !== 8'hCB || ime !== 1'b1) begin errors++; $display("FAIL prefix_load: got ir %h ime %b expected cb 1", ir, ime); end
        clear_inputs(); done = 1'b1; d_in = 8'h7C; irq_req = 5'b00001; cyc();
        checks++; if (ir !== 8'h7C || prefix !== 1'b1 || irq_ack !== 5'b0 || ime !== 1'b1) begin errors++; $display("FAIL prefix_op: got ir %h pfx %b ack %b ime %b expected 7c 1 00000 1", ir, prefix, irq_ack, ime); end
        clear_inputs(); done = 1'b1; d_in = 8'h00; irq_req = 5'b00001; cyc();
        checks++; if (ir !== 8'hD3 || irq_ack !== 5'b00001 || vector !== 8'h40 || ime !== 1'b0 || prefix !== 1'b0) begin errors++; $display("FAIL prefix_after_irq: got ir %h ack %b vec %h ime %b pfx %b expected d3 00001 40 0 0", ir, irq_ack, vector, ime, prefix); end
    endtask

    task automatic test_cond();
        clear_inputs(); cyc(); cyc();
        checks++; if (step !== 3'd2) begin errors++; $display("FAIL cond_step2: got %0d expected 2", step); end
        is_cond = 1'b1; cond = 2'b01; flags = 4'b1000; #1;
        checks++; if (fetch !== 1'b0) begin errors++; $display("FAIL cond_true_fetch: got %b expected 0", fetch); end
        cyc();
        checks++; if (step !== 3'd3) begin errors++; $display("FAIL cond_true_step: got %0d expected 3", step); end
        clear_inputs(); done = 1'b1; cyc();
        clear_inputs(); cyc(); cyc();
        is_cond = 1'b1; cond = 2'b01; flags = 4'b0000; d_in = 8'h21; #1;
        checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL cond_false_fetch: got %b expected 1", fetch); end
        cyc();
        checks++; if (ir !== 8'h21 || step !== 3'd0) begin errors++; $display("FAIL cond_false_end: got ir %h step %0d expected 21 0", ir, step); end
        clear_inputs(); is_cond = 1'b1; cond = 2'b10; flags = 4'b0001; d_in = 8'h31; cyc();
        checks++; if (ir !== 8'h31 || step !== 3'd0) begin errors++; $display("FAIL cond_nc_end: got ir %h step %0d expected 31 0", ir, step); end
    endtask

    task automatic test_irq();
        clear_inputs(); done = 1'b1; reti = 1'b1; cyc();
        clear_inputs(); done = 1'b1; irq_req = 5'b10100; d_in = 8'h77; cyc();
        checks++; if (ir !== 8'hD3 || irq_ack !== 5'b00100 || vector !== 8'h50 || ime !== 1'b0) begin errors++; $display("FAIL irq_dispatch: got ir %h ack %b vec %h ime %b expected d3 00100 50 0", ir, irq_ack, vector, ime); end
        clear_inputs(); cyc();
        checks++; if (irq_ack !== 5'b0 || vector !== 8'h50 || step !== 3'd1) begin errors++; $display("FAIL irq_pulse: got ack %b vec %h step %0d expected 00000 50 1", irq_ack, vector, step); end
    endtask

    task automatic test_ei_delay();
        clear_inputs(); done = 1'b1; ei = 1'b1; cyc();
        checks++; if (ime !== 1'b0 || ir !== 8'h00) begin errors++; $display("FAIL ei_first: got ime %b ir %h expected 0 00", ime, ir); end
        clear_inputs(); done = 1'b1; irq_req = 5'b00001; d_in = 8'h11; cyc();
        checks++; if (ir !== 8'h11 || irq_ack !== 5'b0 || ime !== 1'b1) begin errors++; $display("FAIL ei_no_dispatch: got ir %h ack %b ime %b expected 11 00000 1", ir, irq_ack, ime); end
        clear_inputs(); done = 1'b1; irq_req = 5'b00001; d_in = 8'h22; cyc();
        checks++; if (ir !== 8'hD3 || irq_ack !== 5'b00001 || ime !== 1'b0) begin errors++; $display("FAIL ei_dispatch: got ir %h ack %b ime %b expected d3 00001 0", ir, irq_ack, ime); end
    endtask

    task automatic test_di_with_irq();
        clear_inputs(); done = 1'b1; reti = 1'b1; cyc();
        clear_inputs(); done = 1'b1; di = 1'b1; irq_req = 5'b00010; d_in = 8'h44; cyc();
        checks++; if (ir !== 8'hD3 || irq_ack !== 5'b00010 || vector !== 8'h48 || ime !== 1'b0) begin errors++; $display("FAIL di_irq: got ir %h ack %b vec %h ime %b expected d3 00010 48 0", ir, irq_ack, vector, ime); end
    endtask

    task automatic test_halt();
        clear_inputs(); done = 1'b1; d_in = 8'h76; cyc();
        clear_inputs(); done = 1'b1; halt_req = 1'b1; d_in = 8'h99; cyc();
        checks++; if (halted !== 1'b1 || ir !== 8'h76 || step !== 3'd0) begin errors++; $display("FAIL halt_enter: got halted %b ir %h step %0d expected 1 76 0", halted, ir, step); end
        clear_inputs(); done = 1'b1; #1;
        checks++; if (fetch !== 1'b0) begin errors++; $display("FAIL halt_fetch: got %b expected 0", fetch); end
        cyc();
        checks++; if (halted !== 1'b1 || step !== 3'd0 || ir !== 8'h76) begin errors++; $display("FAIL halt_hold: got halted %b step %0d ir %h expected 1 0 76", halted, step, ir); end
        clear_inputs(); irq_req = 5'b00001; d_in = 8'h5A; cyc();
        checks++; if (ir !== 8'h5A || halted !== 1'b0 || irq_ack !== 5'b0) begin errors++; $display("FAIL halt_exit: got ir %h halted %b ack %b expected 5a 0 00000", ir, halted, irq_ack); end
        clear_inputs(); done = 1'b1; reti = 1'b1; cyc();
        clear_inputs(); done = 1'b1; halt_req = 1'b1; cyc();
        clear_inputs(); irq_req = 5'b00100; d_in = 8'h12; cyc();
        checks++; if (ir !== 8'hD3 || irq_ack !== 5'b00100 || vector !== 8'h50 || halted !== 1'b0 || ime !== 1'b0) begin errors++; $display("FAIL halt_dispatch: got ir %h ack %b vec %h halted %b ime %b expected d3 00100 50 0 0", ir, irq_ack, vector, halted, ime); end
    endtask

    task automatic test_halt_bug();
        clear_inputs(); done = 1'b1; cyc();
        clear_inputs(); done = 1'b1; halt_req = 1'b1; irq_req = 5'b00001; d_in = 8'hAB; cyc();
`ifdef OP_SEQUENCER_HALT_BUG_EN
        checks++; if (halted !== 1'b0 || pc_hold !== 1'b1 || ir !== 8'hAB) begin errors++; $display("FAIL halt_bug: got halted %b pc_hold %b ir %h expected 0 1 ab", halted, pc_hold, ir); end
        clear_inputs(); cyc();
        checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL halt_bug_pulse: got %b expected 0", pc_hold); end
`else
        checks++; if (halted !== 1'b1 || pc_hold !== 1'b0 || ir !== 8'h00) begin errors++; $display("FAIL halt_nobug: got halted %b pc_hold %b ir %h expected 1 0 00", halted, pc_hold, ir); end
        clear_inputs(); irq_req = 5'b00001; d_in = 8'hAB; cyc();
        checks++; if (halted !== 1'b0 || ir !== 8'hAB) begin errors++; $display("FAIL halt_nobug_exit: got halted %b ir %h expected 0 ab", halted, ir); end
`endif
    endtask

    task automatic test_fault();
        clear_inputs(); done = 1'b1; cyc();
        clear_inputs();
        repeat (7) cyc();
        checks++; if (step !== 3'd7 || fault !== 1'b0) begin errors++; $display("FAIL fault_pre: got step %0d fault %b expected 7 0", step, fault); end
        cyc();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b expected 1", fault); end
        done = 1'b1; d_in = 8'h12; irq_req = 5'b00001; cyc(); cyc();
        checks++; if (fault !== 1'b1 || ir !== 8'h00 || step !== 3'd7) begin errors++; $display("FAIL fault_frozen: got fault %b ir %h step %0d expected 1 00 7", fault, ir, step); end
        clear_inputs(); rst = 1'b1; cyc(); rst = 1'b0;
        checks++; if (fault !== 1'b0 || step !== 3'd0 || ir !== 8'h00) begin errors++; $display("FAIL fault_clear: got fault %b step %0d ir %h expected 0 0 00", fault, step, ir); end
    endtask

    task automatic test_random();
        int pick;
        bit exp_fetch;
        for (int n = 0; n < 3000; n++) begin
            clear_inputs();
            rst     = (n == 0) || ($urandom_range(0, 199) == 0);
            done    = ($urandom_range(0, 9) < 4);
            is_cond = ($urandom_range(0, 3) == 0);
            cond    = 2'($urandom);
            flags   = 4'($urandom);
            d_in    = ($urandom_range(0, 7) == 0) ? 8'hCB : 8'($urandom);
            irq_req = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            pick    = $urandom_range(0, 11);
            halt_req = (pick == 0); ei = (pick == 1); di = (pick == 2); reti = (pick == 3);
            #1;
            exp_fetch = !m_fault && !m_halt && m_ends();
            checks++; if (!rst && fetch !== exp_fetch) begin errors++; $display("FAIL rnd_fetch @%0d: got %b expected %b", n, fetch, exp_fetch); end
            model_step();
            cyc();
            checks++; if (ir !== m_ir || step !== m_step || prefix !== m_prefix) begin errors++; $display("FAIL rnd_ir @%0d: got ir %h step %0d pfx %b expected %h %0d %b", n, ir, step, prefix, m_ir, m_step, m_prefix); end
            checks++; if (irq_ack !== m_ack || vector !== m_vec || ime !== m_ime) begin errors++; $display("FAIL rnd_irq @%0d: got ack %b vec %h ime %b expected %b %h %b", n, irq_ack, vector, ime, m_ack, m_vec, m_ime); end
            checks++; if (halted !== m_halt || fault !== m_fault || pc_hold !== m_pch) begin errors++; $display("FAIL rnd_status @%0d: got halted %b fault %b pc_hold %b expected %b %b %b", n, halted, fault, pc_hold, m_halt, m_fault, m_pch); end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_prefix();
        test_cond();
        test_irq();
        test_ei_delay();
        test_di_with_irq();
        test_halt();
        test_halt_bug();
        test_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
